// File: rtl/sha_1_ctrl_if.sv
// Bus bundle for the SHA-1 message sequencer: input word stream, core
// block port, digest output, error flag and an FSM state debug view.
//
// Handshake rule for both in_* and dig_*: a transfer happens on a rising
// clk edge where valid and ready are both 1; the producer holds data stable
// while valid=1 and ready=0, and ready never depends combinationally on valid.
// core_enable / core_ready are single-cycle pulses, not a valid/ready pair.
interface sha_1_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] core_data;
  logic [63:0]  core_index;
  logic         core_enable;
  logic [159:0] core_hash;
  logic         core_ready;
  logic         dig_valid;
  logic         dig_ready;
  logic [159:0] dig_hash;
  logic         err;
  logic [2:0]   dbg_state;

  // Controller side
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_hash, core_ready, dig_ready,
    output in_ready, core_data, core_index, core_enable, dig_valid, dig_hash, err, dbg_state
  );

  // Environment side: message source, core and digest consumer
  modport master (
    output in_valid, in_data, in_last, in_bytes, core_hash, core_ready, dig_ready,
    input  in_ready, core_data, core_index, core_enable, dig_valid, dig_hash, err, dbg_state
  );
endinterface

// File: rtl/sha_1_ctrl.sv
// SHA-1 message sequencer. Packs 32-bit message words into 512-bit blocks,
// appends the 0x80 pad byte and 64-bit bit length, issues each block to the
// sha_1 core and returns the final digest on a valid/ready port.
// Optional build macro: SHA_1_CTRL_TIMEOUT_EN adds a core watchdog that sets
// the sticky err flag and abandons the message when the core stalls.
module sha_1_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  sha_1_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_FIRE    = 3'd1,
    S_WAIT    = 3'd2,
    S_PAD     = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t        state;
  logic [31:0]   blk_buf [16];
  logic [3:0]    wcnt;
  logic [63:0]   bytecnt;
  logic [63:0]   blk;
  logic          msg_end;
  logic          len_done;
  logic          pad_pend;
  logic          in_ready_q;
  logic          core_enable_q;
  logic          dig_valid_q;
  logic [159:0]  dig_hash_q;
  logic          err_q;

`ifdef SHA_1_CTRL_TIMEOUT_EN
  logic [31:0]   tmo_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  logic [2:0]    nb;
  logic [31:0]   last_word;
  logic [4:0]    pad_pos;
  logic [63:0]   bytecnt_nxt;
  logic [63:0]   bitlen_nxt;
  logic [511:0]  core_data_w;
  logic          take;

  // Decode the incoming word: valid byte count, padded last word, pad position
  always_comb begin
    nb = 3'd4;
    if (bus.in_last) nb = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
    // A full last word pushes the 0x80 pad byte into the following word
    pad_pos     = {1'b0, wcnt} + ((nb == 3'd4) ? 5'd1 : 5'd0);
    bytecnt_nxt = bytecnt + {61'd0, nb};
    bitlen_nxt  = bytecnt_nxt << 3;
  end

  // Flatten the block buffer onto the core bus, word i at [i*32 +: 32]
  always_comb begin
    core_data_w = '0;
    for (int i = 0; i < 16; i++) core_data_w[i*32 +: 32] = blk_buf[i];
  end

  assign take            = bus.in_valid & in_ready_q & (state == S_COLLECT);
  assign bus.in_ready    = in_ready_q;
  assign bus.core_data   = core_data_w;
  assign bus.core_index  = blk;
  assign bus.core_enable = core_enable_q;
  assign bus.dig_valid   = dig_valid_q;
  assign bus.dig_hash    = dig_hash_q;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state;

  // Sequencer FSM: collect words, fire blocks, wait for the core, emit digest
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_COLLECT;
      wcnt          <= 4'd0;
      bytecnt       <= 64'd0;
      blk           <= 64'd0;
      msg_end       <= 1'b0;
      len_done      <= 1'b0;
      pad_pend      <= 1'b0;
      in_ready_q    <= 1'b1;
      core_enable_q <= 1'b0;
      dig_valid_q   <= 1'b0;
      dig_hash_q    <= 160'd0;
      err_q         <= 1'b0;
      for (int i = 0; i < 16; i++) blk_buf[i] <= 32'd0;
`ifdef SHA_1_CTRL_TIMEOUT_EN
      tmo_cnt       <= 32'd0;
`endif
    end else begin
      case (state)
        S_COLLECT: begin
          if (take) begin
            bytecnt <= bytecnt_nxt;
            wcnt    <= wcnt + 4'd1;
            if (!bus.in_last) begin
              blk_buf[wcnt] <= bus.in_data;
              if (wcnt == 4'd15) begin
                msg_end       <= 1'b0;
                state         <= S_FIRE;
                in_ready_q    <= 1'b0;
                core_enable_q <= 1'b1;
              end
            end else begin
              // Place the padded last word, the spill-over pad word, zeros after
              for (int i = 0; i < 16; i++) begin
                if (5'(i) == {1'b0, wcnt}) blk_buf[i] <= last_word;
                else if (5'(i) > {1'b0, wcnt})
                  blk_buf[i] <= (5'(i) == pad_pos) ? 32'h8000_0000 : 32'd0;
              end
              // Length fits in this block only if the pad ends by word 13
              if (pad_pos <= 5'd13) begin
                blk_buf[14] <= bitlen_nxt[63:32];
                blk_buf[15] <= bitlen_nxt[31:0];
                len_done    <= 1'b1;
              end else begin
                len_done    <= 1'b0;
              end
              pad_pend      <= (pad_pos == 5'd16);
              msg_end       <= 1'b1;
              state         <= S_FIRE;
              in_ready_q    <= 1'b0;
              core_enable_q <= 1'b1;
            end
          end
        end

        S_FIRE: begin
          core_enable_q <= 1'b0;
          state         <= S_WAIT;
`ifdef SHA_1_CTRL_TIMEOUT_EN
          tmo_cnt       <= 32'd0;
`endif
        end

        S_WAIT: begin
          if (bus.core_ready) begin
            blk  <= blk + 64'd1;
            wcnt <= 4'd0;
            for (int i = 0; i < 16; i++) blk_buf[i] <= 32'd0;
            if (!msg_end) begin
              state      <= S_COLLECT;
              in_ready_q <= 1'b1;
            end else if (!len_done) begin
              state <= S_PAD;
            end else begin
              state       <= S_OUT;
              dig_hash_q  <= bus.core_hash;
              dig_valid_q <= 1'b1;
            end
          end
`ifdef SHA_1_CTRL_TIMEOUT_EN
          else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
            // Core stalled: drop the message and go back to idle collecting
            err_q      <= 1'b1;
            state      <= S_COLLECT;
            in_ready_q <= 1'b1;
            blk        <= 64'd0;
            bytecnt    <= 64'd0;
            wcnt       <= 4'd0;
            msg_end    <= 1'b0;
            len_done   <= 1'b0;
            pad_pend   <= 1'b0;
            for (int i = 0; i < 16; i++) blk_buf[i] <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
`endif
        end

        S_PAD: begin
          // Extra block holding only padding and the bit length
          for (int i = 0; i < 16; i++) blk_buf[i] <= 32'd0;
          blk_buf[0]    <= pad_pend ? 32'h8000_0000 : 32'd0;
          blk_buf[14]   <= bytecnt[60:29];
          blk_buf[15]   <= {bytecnt[28:0], 3'b000};
          len_done      <= 1'b1;
          pad_pend      <= 1'b0;
          state         <= S_FIRE;
          core_enable_q <= 1'b1;
        end

        S_OUT: begin
          if (bus.dig_ready) begin
            dig_valid_q <= 1'b0;
            blk         <= 64'd0;
            bytecnt     <= 64'd0;
            wcnt        <= 4'd0;
            msg_end     <= 1'b0;
            len_done    <= 1'b0;
            pad_pend    <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_COLLECT;
          end
        end

        default: begin
          state      <= S_COLLECT;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_ctrl.sv
// Testbench for sha_1_ctrl: behavioural SHA-1 core, message vector table,
// digest scoreboard and hand-written back-pressure / reset / timeout sequences.
module tb_sha_1_ctrl;

`ifdef SHA_1_CTRL_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  typedef struct packed {
    logic [1023:0] msg;     // word i at [i*32 +: 32]
    logic [4:0]    nwords;
    logic [2:0]    lbytes;
    logic [3:0]    nblk;
    logic [31:0]   w0;      // word 0 of the last block
    logic [31:0]   w15;     // word 15 of the last block
    logic [159:0]  dig;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sha_1_ctrl_if bus();

  sha_1_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [159:0] exp_q [$];
  logic [511:0] blk_q [$];
  logic [63:0]  idx_q [$];
  int           dig_seen  = 0;
  int           stab_bad  = 0;
  int           lat_fixed = 0;
  bit           core_stall = 1'b0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1_comp(input logic [159:0] hin, input logic [511:0] b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = b[i*32 +: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = hin[159:128]; bb = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);           k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                     k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ d;                     k = 32'hca62c1d6; end
      t  = {a[26:0], a[31:27]} + f + e + k + w[i];
      e  = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + bb, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // ---------------- behavioural sha_1 core ----------------
  logic [511:0] cap_blk;
  logic [159:0] chain, res;
  bit           busy = 1'b0;
  int           cnt  = 0;

  always @(negedge clk) begin
    bus.core_ready = 1'b0;
    if (!rst) begin
      busy = 1'b0;
    end else if (busy) begin
      if (bus.core_data !== cap_blk) stab_bad++;
      if (cnt == 0) begin
        bus.core_ready = 1'b1;
        bus.core_hash  = res;
        busy = 1'b0;
      end else begin
        cnt--;
      end
    end else if (bus.core_enable) begin
      cap_blk = bus.core_data;
      blk_q.push_back(bus.core_data);
      idx_q.push_back(bus.core_index);
      if (bus.core_index == 64'd0) chain = IV;
      res   = sha1_comp(chain, cap_blk);
      chain = res;
      busy  = !core_stall;
      cnt   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
    end
  end

  // ---------------- digest scoreboard ----------------
  always @(negedge clk) begin
    if (rst && bus.dig_valid && bus.dig_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_digest", 512'(bus.dig_hash), 512'd0);
      end else begin
        chk("digest", 512'(bus.dig_hash), 512'(exp_q.pop_front()));
      end
      dig_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nbytes;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("in_ready_timeout", 512'd1, 512'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_digest(input string name, input int seen0);
    int n = 0;
    while (dig_seen == seen0 && n < 2000) begin @(negedge clk); n++; end
    chk({name, "_dig_timeout"}, 512'(n >= 2000), 512'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int seen0;
    blk_q.delete(); idx_q.delete(); stab_bad = 0;
    exp_q.push_back(v.dig);
    seen0 = dig_seen;
    for (int i = 0; i < int'(v.nwords); i++)
      send_word(v.msg[i*32 +: 32], (i == int'(v.nwords) - 1),
                (i == int'(v.nwords) - 1) ? v.lbytes : 3'd4);
    wait_digest(name, seen0);
    @(negedge clk);
    chk({name, "_in_ready_after"}, 512'(bus.in_ready), 512'd1);
    chk({name, "_dig_valid_after"}, 512'(bus.dig_valid), 512'd0);
    chk({name, "_nblk"}, 512'(blk_q.size()), 512'(v.nblk));
    for (int k = 0; k < blk_q.size(); k++)
      chk($sformatf("%s_index%0d", name, k), 512'(idx_q[k]), 512'(k));
    if (blk_q.size() > 0) begin
      chk({name, "_last_w0"}, 512'(blk_q[blk_q.size()-1][31:0]), 512'(v.w0));
      chk({name, "_last_w15"}, 512'(blk_q[blk_q.size()-1][511:480]), 512'(v.w15));
    end
    chk({name, "_core_data_stable"}, 512'(stab_bad), 512'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, 512'(bus.in_ready), 512'd1);
    chk({name, "_core_enable"}, 512'(bus.core_enable), 512'd0);
    chk({name, "_core_index"}, 512'(bus.core_index), 512'd0);
    chk({name, "_core_data"}, bus.core_data, 512'd0);
    chk({name, "_dig_valid"}, 512'(bus.dig_valid), 512'd0);
    chk({name, "_dig_hash"}, 512'(bus.dig_hash), 512'd0);
    chk({name, "_err"}, 512'(bus.err), 512'd0);
    chk({name, "_state"}, 512'(bus.dbg_state), 512'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t         vecs [6];
  logic [511:0] pad_blk;
  logic [159:0] h_hold;
  int           n, seen0;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_bytes = 3'd0;
    bus.core_ready = 1'b0; bus.core_hash = '0; bus.dig_ready = 1'b1;

    // Vector table
    vecs[0] = '0;
    vecs[0].msg[31:0] = 32'h61626300; vecs[0].nwords = 5'd1; vecs[0].lbytes = 3'd3;
    vecs[0].nblk = 4'd1; vecs[0].w0 = 32'h61626380; vecs[0].w15 = 32'h18;
    vecs[0].dig = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

    vecs[1] = '0;
    vecs[1].nwords = 5'd1; vecs[1].lbytes = 3'd0; vecs[1].nblk = 4'd1;
    vecs[1].w0 = 32'h80000000; vecs[1].w15 = 32'h0;
    vecs[1].dig = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

    vecs[2] = '0;
    for (int k = 0; k < 14; k++)
      vecs[2].msg[k*32 +: 32] = {8'(97 + k), 8'(98 + k), 8'(99 + k), 8'(100 + k)};
    vecs[2].nwords = 5'd14; vecs[2].lbytes = 3'd4; vecs[2].nblk = 4'd2;
    vecs[2].w0 = 32'h0; vecs[2].w15 = 32'h1c0;
    vecs[2].dig = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    // 64 bytes: the pad word spills into a fresh block
    vecs[3] = '0;
    for (int k = 0; k < 20; k++)
      vecs[3].msg[k*32 +: 32] = {8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)};
    vecs[4] = vecs[3];
    vecs[3].msg[1023:512] = '0;
    vecs[3].nwords = 5'd16; vecs[3].lbytes = 3'd4; vecs[3].nblk = 4'd2;
    vecs[3].w0 = 32'h80000000; vecs[3].w15 = 32'h200;
    pad_blk = '0; pad_blk[31:0] = 32'h80000000; pad_blk[511:480] = 32'h200;
    vecs[3].dig = sha1_comp(sha1_comp(IV, vecs[3].msg[511:0]), pad_blk);

    // 78 bytes: a full 16-word block, then 3 words + 2-byte tail + length
    vecs[4].nwords = 5'd20; vecs[4].lbytes = 3'd2; vecs[4].nblk = 4'd2;
    vecs[4].w0 = 32'h40414243; vecs[4].w15 = 32'h270;
    pad_blk = '0;
    pad_blk[31:0] = 32'h40414243; pad_blk[63:32] = 32'h44454647;
    pad_blk[95:64] = 32'h48494a4b; pad_blk[127:96] = 32'h4c4d8000;
    pad_blk[511:480] = 32'h270;
    vecs[4].dig = sha1_comp(sha1_comp(IV, vecs[4].msg[511:0]), pad_blk);

    // in_bytes above 4 on the last word behaves as 4
    vecs[5] = vecs[2];
    vecs[5].lbytes = 3'd7;

    // Reset
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Table-driven messages
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Digest back-pressure: output held, input refused, then next message at index 0
    bus.dig_ready = 1'b0;
    exp_q.push_back(vecs[0].dig);
    seen0 = dig_seen;
    send_word(32'h61626300, 1'b1, 3'd3);
    n = 0;
    while (!bus.dig_valid && n < 500) begin @(negedge clk); n++; end
    chk("bp_dig_valid_timeout", 512'(n >= 500), 512'd0);
    h_hold = bus.dig_hash;
    bus.in_valid = 1'b1; bus.in_data = 32'hdeadbeef; bus.in_last = 1'b1; bus.in_bytes = 3'd4;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("bp_dig_valid_c%0d", c), 512'(bus.dig_valid), 512'd1);
      chk($sformatf("bp_dig_hash_c%0d", c), 512'(bus.dig_hash), 512'(h_hold));
      chk($sformatf("bp_in_ready_c%0d", c), 512'(bus.in_ready), 512'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.dig_ready = 1'b1;
    wait_digest("bp", seen0);
    @(negedge clk);
    run_vec(vecs[0], "bp_next");

    // Reset during WAIT of block 1
    lat_fixed = 30;
    blk_q.delete(); idx_q.delete();
    for (int i = 0; i < 14; i++)
      send_word(vecs[2].msg[i*32 +: 32], (i == 13), 3'd4);
    n = 0;
    while (blk_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    chk("rstwait_block1_timeout", 512'(n >= 500), 512'd0);
    @(negedge clk); @(negedge clk);
    chk("rstwait_in_wait", 512'(bus.dbg_state), 512'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    lat_fixed = 0;
    @(negedge clk);
    run_vec(vecs[0], "after_rst");

`ifdef SHA_1_CTRL_TIMEOUT_EN
    // Stalled core: watchdog fires, message dropped, no digest
    core_stall = 1'b1;
    blk_q.delete(); idx_q.delete();
    send_word(32'h61626300, 1'b1, 3'd3);
    n = 0;
    while (blk_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
    // blk_q fills at the negedge inside FIRE; WAIT starts at the next edge and
    // err is visible at the negedge after the edge ending the 10th WAIT cycle
    n = 0;
    while (!bus.err && n < 100) begin @(negedge clk); n++; end
    chk("tmo_err_cycle", 512'(n), 512'd11);
    chk("tmo_state", 512'(bus.dbg_state), 512'd0);
    chk("tmo_in_ready", 512'(bus.in_ready), 512'd1);
    chk("tmo_dig_valid", 512'(bus.dig_valid), 512'd0);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 512'(bus.err), 512'd1);
    core_stall = 1'b0;
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("tmo_err_cleared", 512'(bus.err), 512'd0);
    run_vec(vecs[0], "after_tmo");
`else
    chk("err_const", 512'(bus.err), 512'd0);
`endif

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 512'(exp_q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
